// File: rtl/sha256_mining_ctrl_if.sv
// -----------------------------------------------------------------------------
// sha256_mining_ctrl_if
//
// Purpose : Bundles the control/data path between the mining job sequencer and
//           the SHA-256 core it drives.
//
// Signals :
//   core_init          sequencer -> core : start a new hash on core_block
//   core_next          sequencer -> core : continue the running hash on core_block
//   core_mode          sequencer -> core : 1 selects SHA-256
//   core_block  [511:0] sequencer -> core : 512-bit message block
//   core_ready         core -> sequencer : core idle and able to accept an operation
//   core_digest [255:0] core -> sequencer : chaining value after the last operation
//   core_digest_valid  core -> sequencer : core_digest holds a finished result
//
// Modports:
//   master : the sequencer side (sha256_mining_ctrl)
//   slave  : the core side
// -----------------------------------------------------------------------------
interface sha256_mining_ctrl_if;
    logic         core_init;
    logic         core_next;
    logic         core_mode;
    logic [511:0] core_block;
    logic         core_ready;
    logic [255:0] core_digest;
    logic         core_digest_valid;

    modport master (
        output core_init,
        output core_next,
        output core_mode,
        output core_block,
        input  core_ready,
        input  core_digest,
        input  core_digest_valid
    );

    modport slave (
        input  core_init,
        input  core_next,
        input  core_mode,
        input  core_block,
        output core_ready,
        output core_digest,
        output core_digest_valid
    );
endinterface

// File: rtl/sha256_mining_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_mining_ctrl
//
// Purpose : Bitcoin-style proof-of-work job sequencer. For every candidate
//           nonce it runs three SHA-256 core operations
//             1. init  on header block 1 (first 64 header bytes)
//             2. next  on padded header block 2 (last 16 bytes incl. nonce)
//             3. init  on the padded first digest (the second hash)
//           then compares the byte-reversed double hash against the target.
//           The job stops on the first hit, at the end of the nonce range,
//           or after the in-flight nonce once an abort has been seen.
//
// Parameters:
//   NONCE_STEP   increment applied to the nonce after a miss (interleaving)
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle job launch (ignored while busy)
//   abort               stop after the nonce currently being hashed
//   header_in   [639:0] raw 80-byte header, first byte in bits [639:632];
//                       bits [31:0] are replaced by the nonce
//   nonce_start [31:0]  first nonce of the job
//   nonce_end   [31:0]  last nonce of the job (inclusive, may wrap)
//   target      [255:0] hit when byte-reversed double hash <= target
//   core_if             master side of the SHA-256 core interface
//   busy                job in progress
//   done                one-cycle pulse at job end
//   found               last job ended on a hit (held until next start)
//   found_nonce [31:0]  nonce of the hit
//   found_hash [255:0]  byte-reversed double hash of the hit
//   hash_count  [31:0]  nonces fully evaluated in the current/last job
// -----------------------------------------------------------------------------
module sha256_mining_ctrl #(
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        abort,
    input  logic [639:0]                header_in,
    input  logic [31:0]                 nonce_start,
    input  logic [31:0]                 nonce_end,
    input  logic [255:0]                target,
    sha256_mining_ctrl_if.master        core_if,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [31:0]                 found_nonce,
    output logic [255:0]                found_hash,
    output logic [31:0]                 hash_count
);

    typedef enum logic [3:0] {
        IDLE,
        B1_ISSUE,
        B1_WAIT,
        B2_ISSUE,
        B2_WAIT,
        H2_ISSUE,
        H2_WAIT,
        CHECK,
        FINISH
    } state_t;

    // SHA-256 padding tails for the two fixed message lengths used here.
    localparam logic [63:0] HDR_LEN_BITS = 64'd640;
    localparam logic [63:0] DIG_LEN_BITS = 64'd256;

    state_t         state_q, state_d;
    logic [607:0]   hdr_q, hdr_d;             // header_in[639:32]
    logic [255:0]   target_q, target_d;
    logic [31:0]    nonce_end_q, nonce_end_d;
    logic [31:0]    nonce_q, nonce_d;
    logic [31:0]    hash_count_q, hash_count_d;
    logic           found_q, found_d;
    logic [31:0]    found_nonce_q, found_nonce_d;
    logic [255:0]   found_hash_q, found_hash_d;
    logic [255:0]   hash_rev_q, hash_rev_d;
    logic           abort_pend_q, abort_pend_d;
    logic [511:0]   core_block_q, core_block_d;

    logic           core_init_c;
    logic           core_next_c;
    logic           core_done_c;
    logic           hit_c;
    logic           range_end_c;
    logic [255:0]   digest_rev;

    // The nonce field of the header is always overwritten by the running nonce.
    logic           unused_nonce_field;
    assign unused_nonce_field = ^header_in[31:0];

    // Bitcoin compares the double hash as a little-endian number, so the
    // digest bytes are reversed before comparing with the target.
    for (genvar gi = 0; gi < 32; gi++) begin : g_digest_rev
        assign digest_rev[8*gi +: 8] = core_if.core_digest[8*(31-gi) +: 8];
    end

    // A core operation is finished only when the core is both idle and holding
    // a result; valid is cleared by the core on the issue edge, so nothing
    // stale can be seen here.
    assign core_done_c = core_if.core_digest_valid && core_if.core_ready;
    assign hit_c       = (hash_rev_q <= target_q);
    assign range_end_c = (nonce_q == nonce_end_q);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hdr_q         <= '0;
            target_q      <= '0;
            nonce_end_q   <= '0;
            nonce_q       <= '0;
            hash_count_q  <= '0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            hash_rev_q    <= '0;
            abort_pend_q  <= 1'b0;
            core_block_q  <= '0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            target_q      <= target_d;
            nonce_end_q   <= nonce_end_d;
            nonce_q       <= nonce_d;
            hash_count_q  <= hash_count_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            hash_rev_q    <= hash_rev_d;
            abort_pend_q  <= abort_pend_d;
            core_block_q  <= core_block_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        hdr_d         = hdr_q;
        target_d      = target_q;
        nonce_end_d   = nonce_end_q;
        nonce_d       = nonce_q;
        hash_count_d  = hash_count_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        hash_rev_d    = hash_rev_q;
        core_block_d  = core_block_q;
        core_init_c   = 1'b0;
        core_next_c   = 1'b0;
        done          = 1'b0;

        // Abort is remembered for the rest of the job and forgotten once the
        // job ends; an abort in IDLE (even alongside start) is dropped.
        abort_pend_d = abort_pend_q;
        if (state_q == FINISH) begin
            abort_pend_d = 1'b0;
        end else if (state_q != IDLE && abort) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    hdr_d        = header_in[639:32];
                    target_d     = target;
                    nonce_end_d  = nonce_end;
                    nonce_d      = nonce_start;
                    hash_count_d = '0;
                    found_d      = 1'b0;
                    // Block 1 is loaded now so it is stable a cycle before
                    // the first init pulse.
                    core_block_d = header_in[639:128];
                    state_d      = B1_ISSUE;
                end
            end

            B1_ISSUE: begin
                if (core_if.core_ready) begin
                    core_init_c = 1'b1;
                    state_d     = B1_WAIT;
                end
            end

            B1_WAIT: begin
                if (core_done_c) begin
                    core_block_d = {hdr_q[95:0], nonce_q, 32'h8000_0000,
                                    288'h0, HDR_LEN_BITS};
                    state_d      = B2_ISSUE;
                end
            end

            B2_ISSUE: begin
                if (core_if.core_ready) begin
                    core_next_c = 1'b1;
                    state_d     = B2_WAIT;
                end
            end

            B2_WAIT: begin
                // The first digest is captured straight into the padded
                // block-3 image; the block register is its only copy.
                if (core_done_c) begin
                    core_block_d = {core_if.core_digest, 32'h8000_0000,
                                    160'h0, DIG_LEN_BITS};
                    state_d      = H2_ISSUE;
                end
            end

            H2_ISSUE: begin
                if (core_if.core_ready) begin
                    core_init_c = 1'b1;
                    state_d     = H2_WAIT;
                end
            end

            H2_WAIT: begin
                if (core_done_c) begin
                    hash_rev_d = digest_rev;
                    state_d    = CHECK;
                end
            end

            CHECK: begin
                hash_count_d = hash_count_q + 32'd1;
                if (hit_c) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                    found_hash_d  = hash_rev_q;
                    state_d       = FINISH;
                end else if (range_end_c || abort_pend_q || abort) begin
                    state_d = FINISH;
                end else begin
                    // Equality is the only end test, so the range wraps
                    // naturally through 0xFFFFFFFF -> 0.
                    nonce_d      = nonce_q + NONCE_STEP;
                    core_block_d = hdr_q[607:96];
                    state_d      = B1_ISSUE;
                end
            end

            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign core_if.core_init  = core_init_c;
    assign core_if.core_next  = core_next_c;
    assign core_if.core_mode  = 1'b1;
    assign core_if.core_block = core_block_q;

    assign busy        = (state_q != IDLE);
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign found_hash  = found_hash_q;
    assign hash_count  = hash_count_q;

endmodule
